branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/mips_core_pkg.sv | 25 ++
 rtl/branch_predictor_sat_counter2.sv | 22 ++
 rtl/branch_predictor.sv | 93 +++++++++
 tb/tb_branch_predictor.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types: 2-bit branch counter states and the BTB entry layout.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif

package mips_core;

    localparam int unsigned MAX_ADDR_WIDTH = `ADDR_WIDTH;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_state_e;

    // Tags are stored zero-extended to the full address width.
    typedef struct packed {
        logic                      valid;
        logic [MAX_ADDR_WIDTH-1:0] tag;
        logic [MAX_ADDR_WIDTH-1:0] target;
        ctr_state_e                ctr;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Saturating 2-bit taken/not-taken counter step.
module sat_counter2
    import mips_core::*;
(
    input  ctr_state_e cur,
    input  logic       taken,
    output ctr_state_e next
);

    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    always_comb begin
        next = cur;
        case (cur)
            SNT:     next = taken ? WNT : SNT;
            WNT:     next = taken ? WT  : SNT;
            WT:      next = taken ? ST  : WNT;
            ST:      next = taken ? ST  : WT;
            default: next = cur;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters and zero-latency lookup.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history into the index.
module branch_predictor
    import mips_core::*;
#(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic                  o_valid,
    output logic                  o_prediction,
    output logic [ADDR_WIDTH-1:0] o_target,
    input  logic                  i_update_valid,
    input  logic [ADDR_WIDTH-1:0] i_update_pc,
    input  logic                  i_update_taken,
    input  logic [ADDR_WIDTH-1:0] i_update_target
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;

    btb_entry_t            table_q [ENTRIES];
    btb_entry_t            rd_entry, wr_entry, new_entry;
    logic [INDEX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0]      rd_tag, wr_tag;
    logic                  rd_hit, wr_hit, write_en;
    ctr_state_e            ctr_next;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^{i_pc[1:0], i_update_pc[1:0]};
    assign rd_tag = i_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign wr_tag = i_update_pc[ADDR_WIDTH-1:INDEX_BITS+2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [INDEX_BITS-1:0] history_q, history_d;

    assign history_d = i_update_valid ? {history_q[INDEX_BITS-2:0], i_update_taken} : history_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) history_q <= '0;
        else     history_q <= history_d;
    end

    assign rd_idx = i_pc[INDEX_BITS+1:2] ^ history_q;
    assign wr_idx = i_update_pc[INDEX_BITS+1:2] ^ history_q;
`else
    assign rd_idx = i_pc[INDEX_BITS+1:2];
    assign wr_idx = i_update_pc[INDEX_BITS+1:2];
`endif

    assign rd_entry = table_q[rd_idx];
    assign rd_hit   = rd_entry.valid && (rd_entry.tag == MAX_ADDR_WIDTH'(rd_tag));

    assign o_valid      = rd_hit & ~rst;
    assign o_prediction = o_valid & (rd_entry.ctr inside {WT, ST});
    assign o_target     = o_valid ? rd_entry.target[ADDR_WIDTH-1:0] : '0;

    assign wr_entry = table_q[wr_idx];
    assign wr_hit   = wr_entry.valid && (wr_entry.tag == MAX_ADDR_WIDTH'(wr_tag));
    assign write_en = i_update_valid & (wr_hit | i_update_taken);

    sat_counter2 u_ctr (
        .cur   (wr_entry.ctr),
        .taken (i_update_taken),
        .next  (ctr_next)
    );

    always_comb begin
        new_entry = wr_entry;
        if (wr_hit) begin
            new_entry.ctr = ctr_next;
            if (i_update_taken) new_entry.target = MAX_ADDR_WIDTH'(i_update_target);
        end else begin
            new_entry = '{valid: 1'b1, tag: MAX_ADDR_WIDTH'(wr_tag),
                          target: MAX_ADDR_WIDTH'(i_update_target), ctr: WT};
        end
    end

    // NOTE: the table is reset entry-by-entry because lookups must read cleared valid bits immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (write_en) begin
            table_q[wr_idx] <= new_entry;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default build, plain pc index).
module tb_branch_predictor;

    localparam int AW = 26;

    logic          clk;
    logic          rst;
    logic [AW-1:0] i_pc;
    logic          o_valid, o_prediction;
    logic [AW-1:0] o_target;
    logic          upd_valid, upd_taken;
    logic [AW-1:0] upd_pc, upd_target;

    int total = 0;
    int bad   = 0;

    branch_predictor #(.INDEX_BITS(6), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_pc            (i_pc),
        .o_valid         (o_valid),
        .o_prediction    (o_prediction),
        .o_target        (o_target),
        .i_update_valid  (upd_valid),
        .i_update_pc     (upd_pc),
        .i_update_taken  (upd_taken),
        .i_update_target (upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_update(input logic [AW-1:0] pc, input logic taken, input logic [AW-1:0] tgt);
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    task automatic look(input logic [AW-1:0] pc);
        @(negedge clk);
        i_pc = pc;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        i_pc = 26'h40;
        upd_valid = 1'b1; upd_pc = 26'h40; upd_taken = 1'b1; upd_target = 26'h100;
        @(posedge clk);
        @(negedge clk); #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        total++; if (o_prediction !== 1'b0) begin bad++; $display("FAIL reset_pred got=%b want=0", o_prediction); end
        total++; if (o_target !== 26'h0) begin bad++; $display("FAIL reset_target got=%h want=0", o_target); end
        @(negedge clk);
        rst = 1'b0; upd_valid = 1'b0;
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL update_in_reset_ignored got=%b want=0", o_valid); end
    endtask

    task automatic test_first_update;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        upd_valid = 1'b1; upd_pc = 26'h40; upd_taken = 1'b1; upd_target = 26'h100;
        @(posedge clk);
        #1 upd_valid = 1'b0;
        look(26'h40);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL alloc_valid got=%b want=1", o_valid); end
        total++; if (o_prediction !== 1'b1) begin bad++; $display("FAIL alloc_pred got=%b want=1", o_prediction); end
        total++; if (o_target !== 26'h100) begin bad++; $display("FAIL alloc_target got=%h want=100", o_target); end
    endtask

    task automatic test_counter;
        do_update(26'h40, 1'b0, 26'h3F0);   // WT -> WNT
        look(26'h40);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL wnt_valid got=%b want=1", o_valid); end
        total++; if (o_prediction !== 1'b0) begin bad++; $display("FAIL wnt_pred got=%b want=0", o_prediction); end
        total++; if (o_target !== 26'h100) begin bad++; $display("FAIL nt_target_kept got=%h want=100", o_target); end
        do_update(26'h40, 1'b0, 26'h0);     // WNT -> SNT
        look(26'h40);
        total++; if (o_prediction !== 1'b0) begin bad++; $display("FAIL snt_pred got=%b want=0", o_prediction); end
        do_update(26'h40, 1'b0, 26'h0);     // SNT stays SNT
        do_update(26'h40, 1'b1, 26'h104);   // SNT -> WNT
        look(26'h40);
        total++; if (o_prediction !== 1'b0) begin bad++; $display("FAIL snt_saturate_pred got=%b want=0", o_prediction); end
        total++; if (o_target !== 26'h104) begin bad++; $display("FAIL taken_hit_target got=%h want=104", o_target); end
        do_update(26'h40, 1'b1, 26'h108);   // WNT -> WT
        look(26'h40);
        total++; if (o_prediction !== 1'b1) begin bad++; $display("FAIL wt_pred got=%b want=1", o_prediction); end
        do_update(26'h40, 1'b1, 26'h10C);   // WT -> ST
        do_update(26'h40, 1'b1, 26'h10C);   // ST stays ST
        do_update(26'h40, 1'b0, 26'h0);     // ST -> WT
        look(26'h40);
        total++; if (o_prediction !== 1'b1) begin bad++; $display("FAIL st_saturate_pred got=%b want=1", o_prediction); end
        total++; if (o_target !== 26'h10C) begin bad++; $display("FAIL st_target got=%h want=10c", o_target); end
        do_update(26'h40, 1'b0, 26'h0);     // WT -> WNT
        look(26'h40);
        total++; if (o_prediction !== 1'b0) begin bad++; $display("FAIL wt_to_wnt_pred got=%b want=0", o_prediction); end
    endtask

    task automatic test_alias;
        do_update(26'h140, 1'b1, 26'h200);
        look(26'h40);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL alias_old_valid got=%b want=0", o_valid); end
        total++; if (o_target !== 26'h0) begin bad++; $display("FAIL alias_old_target got=%h want=0", o_target); end
        look(26'h140);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL alias_new_valid got=%b want=1", o_valid); end
        total++; if (o_prediction !== 1'b1) begin bad++; $display("FAIL alias_new_pred got=%b want=1", o_prediction); end
        total++; if (o_target !== 26'h200) begin bad++; $display("FAIL alias_new_target got=%h want=200", o_target); end
        do_update(26'h40, 1'b0, 26'h55);    // miss, not taken: no change
        look(26'h140);
        total++; if (o_target !== 26'h200) begin bad++; $display("FAIL miss_nt_kept got=%h want=200", o_target); end
        look(26'h40);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL miss_nt_no_alloc got=%b want=0", o_valid); end
    endtask

    task automatic test_same_cycle;
        @(negedge clk);
        i_pc = 26'h80;
        upd_valid = 1'b1; upd_pc = 26'h80; upd_taken = 1'b1; upd_target = 26'h300;
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL same_cycle_old got=%b want=0", o_valid); end
        @(posedge clk);
        #1 upd_valid = 1'b0;
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL same_cycle_next got=%b want=1", o_valid); end
        total++; if (o_target !== 26'h300) begin bad++; $display("FAIL same_cycle_target got=%h want=300", o_target); end
        look(26'h83);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL low_bits_ignored got=%b want=1", o_valid); end
    endtask

    task automatic test_no_update;
        @(negedge clk);
        upd_valid = 1'b0; upd_pc = 26'hC0; upd_taken = 1'b1; upd_target = 26'h400;
        @(posedge clk);
        look(26'hC0);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL idle_update got=%b want=0", o_valid); end
    endtask

    task automatic test_async_reset;
        look(26'h80);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b want=1", o_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid got=%b want=0", o_valid); end
        total++; if (o_target !== 26'h0) begin bad++; $display("FAIL async_reset_target got=%h want=0", o_target); end
        @(negedge clk); rst = 1'b0;
        look(26'h80);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL post_reset_80 got=%b want=0", o_valid); end
        look(26'h140);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL post_reset_140 got=%b want=0", o_valid); end
    endtask

    initial begin
        rst = 1'b1;
        i_pc = 26'h40;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        repeat (2) @(posedge clk);
        test_reset;
        test_first_update;
        test_counter;
        test_alias;
        test_same_cycle;
        test_no_update;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
